// File: rtl/line_buffer_scheduler.sv
// Four-bank line-buffer controller: primes four rows, then streams 4-row column windows
// while refilling the oldest bank. Optional stall counter port: LB_STALL_COUNT_EN.
module line_buffer_scheduler #(
    parameter  int IMG_W = 512,
    parameter  int IMG_H = 512,
    localparam int CW    = $clog2(IMG_W)
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          bram_we,
    output logic [CW+1:0] bram_waddr,
    output logic          bram_re,
    output logic [CW-1:0] bram_rcol,
    output logic [1:0]    rot_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef LB_STALL_COUNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROWS_PRIMED = RW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [1:0]    wbank_q, wbank_d;
    logic [CW-1:0] rcol_q, rcol_d;
    logic [1:0]    rot_sel_q, rot_sel_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic slot_free;
    logic fire;
    logic accept;

    // The output register can take a new column when empty or being consumed this cycle.
    assign slot_free = !out_valid_q || out_ready;

    // Enables are decoded from registered state and the same-cycle handshakes, so an
    // asserted rst suppresses any BRAM access already in the cycle it is applied.
    always_comb begin
        fire     = 1'b0;
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_PRIME: in_ready = 1'b1;
                S_STREAM: begin
                    fire     = slot_free && in_valid;
                    in_ready = fire;
                end
                S_DRAIN: fire = slot_free;
                default: begin
                    fire     = 1'b0;
                    in_ready = 1'b0;
                end
            endcase
        end
    end

    assign accept     = in_valid && in_ready;
    assign bram_we    = accept;
    assign bram_re    = fire;
    assign bram_waddr = (state_q == S_PRIME) ? {wbank_q, wcol_q} : {rot_sel_q, rcol_q};
    assign bram_rcol  = rcol_q;
    assign rot_sel    = rot_sel_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d   = state_q;
        wcol_d    = wcol_q;
        wbank_d   = wbank_q;
        rcol_d    = rcol_q;
        rot_sel_d = rot_sel_q;
        row_cnt_d = row_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                wcol_d    = '0;
                wbank_d   = '0;
                rcol_d    = '0;
                rot_sel_d = '0;
                row_cnt_d = '0;
                if (start) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                if (accept) begin
                    wcol_d = wcol_q + CW'(1);
                    if (wcol_q == COL_LAST) begin
                        wbank_d = wbank_q + 2'd1;
                        if (wbank_q == 2'd3) begin
                            state_d   = S_STREAM;
                            row_cnt_d = ROWS_PRIMED;
                        end
                    end
                end
            end
            S_STREAM: begin
                // Incoming pixel overwrites the oldest row at the column being read out.
                if (fire) begin
                    rcol_d = rcol_q + CW'(1);
                    if (rcol_q == COL_LAST) begin
                        rot_sel_d = rot_sel_q + 2'd1;
                        row_cnt_d = row_cnt_q + RW'(1);
                        if (row_cnt_q == ROW_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    rcol_d = rcol_q + CW'(1);
                    if (rcol_q == COL_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Wait for the last column to leave before signalling completion.
                if (slot_free) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    wcol_d    = '0;
                    wbank_d   = '0;
                    rcol_d    = '0;
                    rot_sel_d = '0;
                    row_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = fire ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcol_q      <= '0;
            wbank_q     <= '0;
            rcol_q      <= '0;
            rot_sel_q   <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcol_q      <= wcol_d;
            wbank_q     <= wbank_d;
            rcol_q      <= rcol_d;
            rot_sel_q   <= rot_sel_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LB_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_STREAM || state_q == S_DRAIN) && out_valid_q && !out_ready
                     && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Bench for line_buffer_scheduler (8x6 image): a read-first 4-bank BRAM model fed with
// pixel indices, so every output column is checked against the image rows it must contain.
module tb_line_buffer_scheduler;

    localparam int W         = 8;
    localparam int H         = 6;
    localparam int CW        = 3;
    localparam int NPIX      = W * H;
    localparam int NXFER     = W * (H - 3);
    localparam int PRIME_PIX = 4 * W;

    logic          CLK       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          bram_we;
    logic [CW+1:0] bram_waddr;
    logic          bram_re;
    logic [CW-1:0] bram_rcol;
    logic [1:0]    rot_sel;
    logic          out_valid;
    logic          busy;
    logic          done;
`ifdef LB_STALL_COUNT_EN
    logic [15:0]   stall_cnt;
`endif

    line_buffer_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bram_we   (bram_we),
        .bram_waddr(bram_waddr),
        .bram_re   (bram_re),
        .bram_rcol (bram_rcol),
        .rot_sel   (rot_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef LB_STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Read-first line buffer; the steer select travels with the read data.
    int         mem [4][W];
    int         bram_q [4];
    logic [1:0] rd_rot;
    int         pix_in;

    always @(posedge CLK) begin
        if (bram_we) mem[bram_waddr[CW+1:CW]][bram_waddr[CW-1:0]] <= pix_in;
        if (bram_re) begin
            for (int j = 0; j < 4; j++) bram_q[j] <= mem[j][bram_rcol];
            rd_rot <= rot_sel;
        end
    end

    typedef struct {
        int iv_pct;
        bit iv_toggle;
        int or_pct;
        bit mid_start;
        int exp_writes;
        int exp_xfers;
        int exp_done;
    } vec_t;

    vec_t vecs [5];

    int n_pass   = 0;
    int n_total  = 0;
    int wr_cnt   = 0;
    int tr_cnt   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // One clock: drive at the falling edge, sample just after, score against the image model.
    task automatic cycle(input bit iv, input bit ordy, input bit st, input bit rs);
        int r, c, w;
        @(negedge CLK);
        in_valid  = iv;
        out_ready = ordy;
        start     = st;
        rst       = rs;
        #1;
        if (!iv)
            check("access_without_in_valid",
                  {bram_we, bram_re && wr_cnt >= PRIME_PIX && wr_cnt < NPIX}, 0);
        if (bram_we) begin
            r = wr_cnt / W;
            c = wr_cnt % W;
            check("write_addr", bram_waddr, (r % 4) * W + c);
            if (wr_cnt >= PRIME_PIX) begin
                check("stream_read_with_write", bram_re, 1);
                check("write_col_eq_read_col", bram_rcol, c);
            end
            pix_in = wr_cnt;
            wr_cnt++;
        end
        if (out_valid && ordy) begin
            w = tr_cnt / W;
            c = tr_cnt % W;
            check("window_rot_sel", rd_rot, w % 4);
            for (int j = 0; j < 4; j++)
                check("window_pixel", bram_q[(rd_rot + j) % 4], (w + j) * W + c);
            $display("xfer %0d: window %0d col %0d rot %0d rows %0d %0d %0d %0d", tr_cnt, w, c,
                     rd_rot, bram_q[rd_rot], bram_q[(rd_rot + 1) % 4],
                     bram_q[(rd_rot + 2) % 4], bram_q[(rd_rot + 3) % 4]);
            tr_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_after_last_transfer", tr_cnt, NXFER);
        end
        if (rs) begin
            wr_cnt = 0;
            tr_cnt = 0;
        end
    endtask

    task automatic begin_run();
        done_cnt = 0;
        wr_cnt   = 0;
        tr_cnt   = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic finish_run(input vec_t v);
        int n;
        bit iv, ordy, st;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            iv   = v.iv_toggle ? (n % 2 == 0) : ($urandom_range(99) < v.iv_pct);
            ordy = $urandom_range(99) < v.or_pct;
            st   = v.mid_start && (wr_cnt == PRIME_PIX + 5);
            cycle(iv, ordy, st, 1'b0);
            n++;
        end
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("writes", wr_cnt, v.exp_writes);
        check("transfers", tr_cnt, v.exp_xfers);
        check("done_pulses", done_cnt, v.exp_done);
        check("idle_after_done", {busy, out_valid, in_ready, bram_we, bram_re}, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{100, 1'b0, 100, 1'b0, NPIX, NXFER, 1};  // full rate
        vecs[1] = '{100, 1'b1, 100, 1'b0, NPIX, NXFER, 1};  // in_valid toggles 1/0
        vecs[2] = '{100, 1'b0, 100, 1'b1, NPIX, NXFER, 1};  // start pulsed mid-stream
        vecs[3] = '{60,  1'b0, 60,  1'b0, NPIX, NXFER, 1};  // random both sides
        vecs[4] = '{90,  1'b0, 35,  1'b0, NPIX, NXFER, 1};  // heavy back-pressure

        // Reset with start and in_valid also asserted: reset must win.
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_busy", busy, 0);
        check("reset_enables", {in_ready, bram_we, bram_re, out_valid, done}, 0);
        check("reset_addrs", {bram_waddr, bram_rcol, rot_sel}, 0);

        for (int i = 0; i < 5; i++) begin
            begin_run();
            finish_run(vecs[i]);
        end

        // Five cycles of back-pressure in the middle of the stream.
        begin_run();
        n = 0;
        while (tr_cnt < 10 && n < 500) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("reached_mid_stream", tr_cnt, 10);
        repeat (5) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", in_ready, 0);
            check("stall_bram_re", bram_re, 0);
            check("stall_out_valid", out_valid, 1);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef LB_STALL_COUNT_EN
        check("stall_cnt", stall_cnt, 5);
`endif
        finish_run(vecs[0]);

        // Reset on the tenth priming pixel, then a fresh image must start again at {0,0}.
        begin_run();
        n = 0;
        while (wr_cnt < 9 && n < 100) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("reached_ninth_write", wr_cnt, 9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("after_rst_busy", busy, 0);
        check("after_rst_enables", {bram_we, bram_re, in_ready, out_valid, done}, 0);
        begin_run();
        finish_run(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/line_buffer_scheduler.md
LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 Parameter IMG_W, default 512, image width in pixels; power of two, 4..1024.
REQ-002 Parameter IMG_H, default 512, image height in rows; 5..1024.
REQ-003 Line buffer depth is fixed at 4 rows (banks 0..3); CW = log2(IMG_W).
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to process one image; honoured only in IDLE.
REQ-007 in_valid  in  1  external-memory pixel available.
REQ-008 in_ready  out  1  scheduler accepts pixel this cycle (accept = in_valid && in_ready).
REQ-009 bram_we  out  1  port-A write enable.
REQ-010 bram_waddr  out  CW+2  port-A address {bank[1:0], col[CW-1:0]}.
REQ-011 bram_re  out  1  port-B read enable; reads column bram_rcol of all 4 banks together.
REQ-012 bram_rcol  out  CW  port-B column address.
REQ-013 rot_sel  out  2  bank holding the oldest row of the current window, for the steer muxes.
REQ-014 out_valid  out  1  4-pixel column on the BRAM port-B output is valid.
REQ-015 out_ready  in  1  downstream consumes the column (transfer = out_valid && out_ready).
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of image.

Function
REQ-018 States: IDLE, PRIME, STREAM, DRAIN, DONE; all outputs registered.
REQ-019 IDLE -> PRIME on start; all enables low; wcol, wbank, rcol, row_cnt, win_cnt, rot_sel cleared.
REQ-020 PRIME: in_ready=1; bram_we=accept; bram_waddr={wbank,wcol}; wcol increments per accept, wraps at IMG_W-1 and increments wbank.
REQ-021 PRIME -> STREAM on the accept writing {3, IMG_W-1} (4*IMG_W pixels); row_cnt=4 on exit.
REQ-022 Advance condition in STREAM and DRAIN: fire = (!out_valid || out_ready), additionally gated by in_valid in STREAM.
REQ-023 STREAM on fire: bram_re=1, bram_rcol=rcol, bram_we=1, bram_waddr={rot_sel, rcol}; in_ready=fire; BRAM port A/B is read-first so the same-cycle read returns the old row.
REQ-024 rcol increments per fire; at rcol=IMG_W-1 it wraps to 0, rot_sel increments mod 4, win_cnt and row_cnt increment.
REQ-025 STREAM -> DRAIN on the fire that writes column IMG_W-1 of row IMG_H-1 (row_cnt reaches IMG_H).
REQ-026 DRAIN: in_ready=0, bram_we=0; bram_re=fire; reads final window (IMG_W columns); -> DONE after the fire at rcol=IMG_W-1.
REQ-027 out_valid set the cycle after bram_re; held while !out_ready; cleared on transfer with no new bram_re; bram_re low during hold keeps BRAM output stable.
REQ-028 Total windows emitted = IMG_H-3, each IMG_W columns; rot_sel for window k = k mod 4.
REQ-029 DONE: done=1 for exactly one cycle only after the final out_valid transfer, then IDLE; start in any non-IDLE state is ignored.
REQ-030 in_valid low stalls STREAM without any BRAM access; out_ready low never drops accepted pixels.

Reset
REQ-031 On rst (any state, mid-image included) the next edge gives state=IDLE, all outputs 0, all counters 0; no further bram_we/bram_re until new start.
REQ-032 rst overrides start and in_valid in the same cycle.

Configuration
REQ-033 Macro LB_STALL_COUNT_EN defined: extra output stall_cnt (16 bit) counts STREAM/DRAIN cycles with out_valid && !out_ready, saturating at 16'hFFFF, cleared on start and rst.
REQ-034 Macro LB_STALL_COUNT_EN undefined: stall_cnt port and logic absent; all other behaviour identical.

Verification (IMG_W=8, IMG_H=6 unless stated)
REQ-035 start, in_valid=1, out_ready=1 -> 32 writes {0,0}..{3,7}, then STREAM; total 3 windows x 8 columns out_valid, rot_sel 0,1,2; done pulse after 24th transfer.
REQ-036 STREAM, column 3 of window 0 -> bram_we to {0,3} with bram_rcol=3 same cycle; out data = row 0 pixel, not new row 4.
REQ-037 out_ready low 5 cycles mid-STREAM -> in_ready=0, bram_re=0, out_valid held, no pixel lost; with LB_STALL_COUNT_EN stall_cnt=5.
REQ-038 in_valid toggling 1/0 throughout -> identical output column sequence to REQ-035, no BRAM access on in_valid=0 cycles.
REQ-039 rst asserted at 10th write of PRIME -> next cycle busy=0, bram_we=0; new start replays writes from {0,0}.
REQ-040 start pulsed during STREAM -> ignored; default IMG_W=512, IMG_H=512 run -> 509 windows, 260608 transfers, one done pulse.
